// File: rtl/laser_cover_param.sv
// Two-circle laser coverage engine: loads one frame of points, then searches the
// grid by alternating coordinate descent for two centres covering the most points.
module laser_cover_param #(
   parameter int unsigned N_PTS    = 40,
   parameter int unsigned CW       = 4,
   parameter int unsigned PAR      = 10,
   parameter int unsigned MAX_PASS = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         IN_VALID,
   output logic                         IN_READY,
   input  logic [CW-1:0]                X,
   input  logic [CW-1:0]                Y,
   input  logic [2*CW:0]                R2,
   output logic [CW-1:0]                C1X,
   output logic [CW-1:0]                C1Y,
   output logic [CW-1:0]                C2X,
   output logic [CW-1:0]                C2Y,
   output logic [$clog2(N_PTS+1)-1:0]   COUNT,
   output logic                         BUSY,
   output logic                         DONE
);

   localparam int unsigned BEATS = (N_PTS + PAR - 1) / PAR;
   localparam int unsigned CNT_W = $clog2(N_PTS + 1);
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned PW    = $clog2(MAX_PASS + 1) + 1;
   localparam int unsigned POS_W = 2 * CW;
   localparam int unsigned SW    = 2 * CW + 1;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_EVAL = 2'd1,
      S_CMP  = 2'd2,
      S_PEND = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]    pt_x [N_PTS];
   logic [CW-1:0]    pt_y [N_PTS];
   logic [CNT_W-1:0] load_cnt_q;
   logic [2*CW:0]    r2_q;

   logic [BW-1:0]    beat_q;
   logic [POS_W-1:0] cand_q;
   logic [PW-1:0]    pass_q;
   logic             mv_c2_q;
   logic [POS_W-1:0] c1_q, c2_q;
   logic [N_PTS-1:0] bm1_q, bm2_q;
   logic [CNT_W-1:0] cur_cnt_q;
   logic [POS_W-1:0] best_pos_q;
   logic [N_PTS-1:0] best_bm_q;
   logic [CNT_W-1:0] best_cnt_q;
   logic [N_PTS-1:0] cand_bm_q;

   logic             accept_c, start_c, beat_c, cmp_c, pend_c, finish_c, stop_c;
   logic [CW-1:0]    lane_x [PAR];
   logic [CW-1:0]    lane_y [PAR];
   logic             lane_v [PAR];
   logic [PAR-1:0]   lane_hit_c;
   logic [N_PTS-1:0] fixed_bm_c;
   logic [CNT_W-1:0] union_cnt_c;
   logic [POS_W-1:0] fin_c1_c, fin_c2_c;

   function automatic logic [SW-1:0] dist2(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                           input logic [CW-1:0] bx, input logic [CW-1:0] by);
      logic [CW-1:0] dx, dy;
      dx = (ax >= bx) ? (ax - bx) : (bx - ax);
      dy = (ay >= by) ? (ay - by) : (by - ay);
      return SW'((POS_W)'(dx) * (POS_W)'(dx)) + SW'((POS_W)'(dy) * (POS_W)'(dy));
   endfunction

   function automatic logic [CNT_W-1:0] popcnt(input logic [N_PTS-1:0] v);
      logic [CNT_W-1:0] s;
      s = '0;
      for (int i = 0; i < N_PTS; i++) s = s + CNT_W'(v[i]);
      return s;
   endfunction

   // Search stops once a later pass fails to improve, or the pass budget is spent.
   assign stop_c = ((pass_q != PW'(1)) && !(best_cnt_q > cur_cnt_q)) ||
                   (pass_q == PW'(MAX_PASS));

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_LOAD;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD: if (IN_VALID && (load_cnt_q == CNT_W'(N_PTS - 1))) state_d = S_EVAL;
         S_EVAL: if (beat_q == BW'(BEATS - 1)) state_d = S_CMP;
         S_CMP:  state_d = (cand_q == '1) ? S_PEND : S_EVAL;
         S_PEND: state_d = stop_c ? S_LOAD : S_EVAL;
         default: state_d = S_LOAD;
      endcase
   end

   // Control strobes per state
   always_comb begin
      accept_c = 1'b0;
      start_c  = 1'b0;
      beat_c   = 1'b0;
      cmp_c    = 1'b0;
      pend_c   = 1'b0;
      finish_c = 1'b0;
      case (state_q)
         S_LOAD: begin
            accept_c = IN_VALID;
            start_c  = IN_VALID && (load_cnt_q == CNT_W'(N_PTS - 1));
         end
         S_EVAL: beat_c = 1'b1;
         S_CMP:  cmp_c  = 1'b1;
         S_PEND: begin
            pend_c   = 1'b1;
            finish_c = stop_c;
         end
         default: ;
      endcase
   end

   // Route the current beat's points onto the comparator lanes; missing lanes stay invalid
   always_comb begin
      for (int l = 0; l < PAR; l++) begin
         lane_x[l] = '0;
         lane_y[l] = '0;
         lane_v[l] = 1'b0;
      end
      for (int i = 0; i < N_PTS; i++) begin
         if (beat_q == BW'(i / PAR)) begin
            lane_x[i % PAR] = pt_x[i];
            lane_y[i % PAR] = pt_y[i];
            lane_v[i % PAR] = 1'b1;
         end
      end
   end

   always_comb begin
      lane_hit_c = '0;
      for (int l = 0; l < PAR; l++)
         lane_hit_c[l] = lane_v[l] &&
                         (dist2(lane_x[l], lane_y[l], cand_q[CW-1:0], cand_q[POS_W-1:CW]) <= r2_q);
   end

   always_comb begin
      fixed_bm_c  = mv_c2_q ? bm1_q : bm2_q;
      union_cnt_c = popcnt(cand_bm_q | fixed_bm_c);
      fin_c1_c    = mv_c2_q ? c1_q : best_pos_q;
      fin_c2_c    = mv_c2_q ? best_pos_q : c2_q;
   end

   // Datapath and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < N_PTS; i++) begin
            pt_x[i] <= '0;
            pt_y[i] <= '0;
         end
         load_cnt_q <= '0;
         r2_q       <= '0;
         beat_q     <= '0;
         cand_q     <= '0;
         pass_q     <= '0;
         mv_c2_q    <= 1'b0;
         c1_q       <= '0;
         c2_q       <= '0;
         bm1_q      <= '0;
         bm2_q      <= '0;
         cur_cnt_q  <= '0;
         best_pos_q <= '0;
         best_bm_q  <= '0;
         best_cnt_q <= '0;
         cand_bm_q  <= '0;
         IN_READY   <= 1'b1;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         C1X        <= '0;
         C1Y        <= '0;
         C2X        <= '0;
         C2Y        <= '0;
         COUNT      <= '0;
      end else begin
         IN_READY <= (state_d == S_LOAD);
         DONE     <= 1'b0;

         if (accept_c) begin
            for (int i = 0; i < N_PTS; i++) begin
               if (load_cnt_q == CNT_W'(i)) begin
                  pt_x[i] <= X;
                  pt_y[i] <= Y;
               end
            end
            if (load_cnt_q == '0) begin
               r2_q <= R2;
               BUSY <= 1'b1;
            end
            load_cnt_q <= start_c ? '0 : (load_cnt_q + CNT_W'(1));
         end

         // Frame complete: pass 1 moves C1 against an empty second circle
         if (start_c) begin
            pass_q     <= PW'(1);
            mv_c2_q    <= 1'b0;
            c1_q       <= '0;
            c2_q       <= '0;
            bm1_q      <= '0;
            bm2_q      <= '0;
            cur_cnt_q  <= '0;
            best_pos_q <= '0;
            best_bm_q  <= '0;
            best_cnt_q <= '0;
            cand_q     <= '0;
            beat_q     <= '0;
         end

         if (beat_c) begin
            for (int i = 0; i < N_PTS; i++)
               if (beat_q == BW'(i / PAR)) cand_bm_q[i] <= lane_hit_c[i % PAR];
            beat_q <= (beat_q == BW'(BEATS - 1)) ? '0 : (beat_q + BW'(1));
         end

         if (cmp_c) begin
            if (union_cnt_c > best_cnt_q) begin
               best_cnt_q <= union_cnt_c;
               best_pos_q <= cand_q;
               best_bm_q  <= cand_bm_q;
            end
            cand_q <= cand_q + POS_W'(1);
         end

         // Commit the mover, then seed the next pass's best from the other circle
         if (pend_c) begin
            if (mv_c2_q) begin
               c2_q       <= best_pos_q;
               bm2_q      <= best_bm_q;
               best_pos_q <= c1_q;
               best_bm_q  <= bm1_q;
            end else begin
               c1_q       <= best_pos_q;
               bm1_q      <= best_bm_q;
               best_pos_q <= c2_q;
               best_bm_q  <= bm2_q;
            end
            cur_cnt_q <= best_cnt_q;
            mv_c2_q   <= ~mv_c2_q;
            pass_q    <= pass_q + PW'(1);
            if (finish_c) begin
               C1X   <= fin_c1_c[CW-1:0];
               C1Y   <= fin_c1_c[POS_W-1:CW];
               C2X   <= fin_c2_c[CW-1:0];
               C2Y   <= fin_c2_c[POS_W-1:CW];
               COUNT <= best_cnt_q;
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/laser_cover_param.md
Name: laser_cover_param

Overview:
- Parametrised successor of the two-circle laser coverage engine.
- Accepts N_PTS points over a valid/ready stream, plus a runtime squared radius.
- Searches a 2^CW x 2^CW grid with alternating coordinate descent for two circle centres that maximise the number of covered points.
- Reports C1/C2 coordinates and the covered count, then pulses DONE. Sits behind the point-source stream; the result is consumed by the scoring/output block.

Parameters:
- N_PTS, 40, points per frame (>=2).
- CW, 4, coordinate width; grid G = 2^CW per axis.
- PAR, 10, in-circle comparator lanes; BEATS = ceil(N_PTS/PAR).
- MAX_PASS, 8, maximum search passes (>=1).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- IN_VALID  in  1  point valid.
- IN_READY  out  1  high only in LOAD.
- X  in  CW  point x.
- Y  in  CW  point y.
- R2  in  2*CW+1  squared radius; sampled with the first accepted point of a frame.
- C1X, C1Y, C2X, C2Y  out  CW each  result centres.
- COUNT  out  clog2(N_PTS+1)  union coverage of the result.
- BUSY  out  1  high from the first accepted point until DONE.
- DONE  out  1  one-cycle pulse, result valid.

Behaviour:
- Interface: one clock CLK; RST is synchronous, active-high.
- Reset values: all outputs 0 except IN_READY=1. FSM enters LOAD and clears the point store.
- RST mid-operation: abort at the next edge; discard all stored points; IN_READY=1 in the following cycle.
- LOAD:
  - A point is accepted when IN_VALID & IN_READY.
  - Points are stored in arrival order, index 0..N_PTS-1. Bubbles are allowed.
  - After the N_PTS-th accept, IN_READY drops in the next cycle. No further input is accepted until DONE.
- Coverage test: a point is covered when (px-cx)^2 + (py-cy)^2 <= R2.
  - Unsigned absolute differences; squares are 2*CW bits, sum is 2*CW+1 bits; no truncation.
- Candidate evaluation:
  - Takes BEATS cycles, PAR points per cycle; lanes beyond N_PTS in the last beat read as uncovered.
  - Then 1 compare cycle, where the union popcount is computed against the fixed circle's stored coverage bitmap.
  - Total: BEATS+1 cycles per candidate.
- Raster order: {y,x} = 0..G*G-1, x increments first; no wrap beyond G*G-1.
- Pass 1: scan C1 with no second circle (count = single-circle coverage). C2 stays (0,0).
- Passes 2, 3, ...: alternately rescan C2 (C1 fixed), then C1 (C2 fixed).
- Best-tracking within a pass:
  - The best is initialised to the moving circle's current position and the current union count.
  - It is replaced only when a candidate's count is strictly greater. Ties keep the earlier/current position.
  - A candidate equal to the fixed circle's position is allowed.
- PASS_END: 1 cycle after each pass. Commit the best position and count; store the moving circle's bitmap.
- Termination, at PASS_END:
  - pass >= 2 and no strict improvement in this pass, or
  - pass == MAX_PASS.
- Timing: pass length = G*G*(BEATS+1)+1 cycles. DONE is high exactly P*(G*G*(BEATS+1)+1)+1 cycles after the cycle of the final accepted point, where P = passes executed.
- Result holding: C1X/C1Y/C2X/C2Y/COUNT update at the DONE cycle and are held until the next DONE or RST. BUSY falls with DONE.
- After DONE: return to LOAD, IN_READY=1. Intermediate values are not visible on the outputs.

Test Plan:
- Default params, R2=16, all 40 points (3,3) -> C1=(1,0), C2=(0,0), COUNT=40, P=2; DONE 2563 cycles after the last accept.
- R2=4, 20 points at (2,2) then 20 at (13,13) -> C1=(2,0), C2=(13,11), COUNT=40, P=3; DONE at 3*1281+1=3844 cycles.
- Load with IN_VALID toggling every other cycle -> exactly 40 accepts; a 41st valid point is not accepted (IN_READY=0); result identical to the gap-free load.
- RST pulsed 500 cycles into a search, then a fresh frame of 40 points at (8,8) with R2=0 -> C1=(8,8), C2=(0,0), COUNT=40; no DONE from the aborted frame.
- MAX_PASS=1 build, scenario-2 data -> C1=(2,0), C2=(0,0), COUNT=20; DONE 1282 cycles after the last accept.
- N_PTS=7, PAR=3 (BEATS=3), R2=0, all points at (15,15) -> C1=(15,15), COUNT=7; padded lanes never counted.
